// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED PIO sequencer.
// Holds the FSM state type, the CSR and PIO word addresses, the CTRL/STATUS/ENTRY bit
// positions and a helper that maps an entry's write mode to a PIO register address.
// Optional feature macro: LED_SEQ_SETCLR_EN (set/clear write modes, see led_pio_sequencer).
package led_seq_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StWrite = 3'd2,
        StHold  = 3'd3,
        StNext  = 3'd4
    } seq_state_e;

    // CSR word addresses
    localparam logic [3:0] CSR_CTRL       = 4'd0;
    localparam logic [3:0] CSR_STATUS     = 4'd1;
    localparam logic [3:0] CSR_LEN        = 4'd2;
    localparam logic [3:0] CSR_ENTRY_BASE = 4'd8;

    // PIO word addresses
    localparam logic [2:0] PIO_DATA = 3'd0;
    localparam logic [2:0] PIO_SET  = 3'd4;
    localparam logic [2:0] PIO_CLR  = 3'd5;

    // CTRL bits
    localparam int unsigned CTRL_RUN    = 0;
    localparam int unsigned CTRL_LOOP   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    // STATUS bits
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_IDX_LSB = 4;
    localparam int unsigned STAT_DONE    = 8;

    // ENTRY fields
    localparam int unsigned ENTRY_MODE_LSB = 8;
    localparam int unsigned ENTRY_DUR_LSB  = 16;

    // Mode 2'b11 is reserved and behaves as a direct write.
    function automatic logic [2:0] mode_to_addr(input logic [1:0] mode);
        logic [2:0] addr;
        case (mode)
            2'b01:   addr = PIO_SET;
            2'b10:   addr = PIO_CLR;
            default: addr = PIO_DATA;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Hold-time timer for the LED sequencer.
// A prescaler divides clk by TICK_DIV into ticks; a tick counter counts up to the duration.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : holds both counters at zero (asserted whenever the FSM is not in HOLD)
//   duration     : hold time in ticks
//   expire       : high in the last cycle of the hold; duration 0 expires on the first cycle
module led_seq_tick #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DUR_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [DUR_W-1:0] duration,
    output logic             expire
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [DUR_W-1:0] tick_q, tick_d;
    logic             tick_end;

    assign tick_end = (presc_q == PMAX);

    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        if (clear) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (tick_end) begin
            presc_d = '0;
            tick_d  = tick_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Hold lasts duration*TICK_DIV cycles: expire on the last prescaler count of the last tick.
    assign expire = ~clear & ((duration == '0) | (tick_end & (tick_q == duration - 1'b1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

endmodule

// File: rtl/led_pio_sequencer.sv
// LED PIO pattern sequencer.
// Software fills a table of (pattern, duration) entries via the CSR slave and sets RUN; the
// block then writes each pattern to the LED PIO through an Avalon-MM master, holds it for its
// duration, optionally loops, and flags DONE (with optional level IRQ) at the end.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   csr_*                 : Avalon-MM CSR slave, zero-wait-state reads
//   m_*                   : Avalon-MM master towards the PIO (honours m_waitrequest)
//   irq                   : DONE & IRQ_EN
// Optional feature macro: LED_SEQ_SETCLR_EN -- ENTRY[9:8] selects direct/set/clear PIO address.
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned LED_W    = 7,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DUR_W    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  csr_address,
    input  logic        csr_chipselect,
    input  logic        csr_write_n,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        irq
);

    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DEPTH_L = 4'(DEPTH);

    seq_state_e       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             run_q, run_d, loop_q, loop_d, irq_en_q, irq_en_d, done_q, done_d;
    logic [3:0]       len_q, len_d;
    logic [LED_W-1:0] pat_q [DEPTH];
    logic [LED_W-1:0] pat_d [DEPTH];
    logic [DUR_W-1:0] dur_q [DEPTH];
    logic [DUR_W-1:0] dur_d [DEPTH];
    logic [LED_W-1:0] out_pat_q, out_pat_d;
    logic [DUR_W-1:0] out_dur_q, out_dur_d;
`ifdef LED_SEQ_SETCLR_EN
    logic [1:0]       mode_q [DEPTH];
    logic [1:0]       mode_d [DEPTH];
    logic [2:0]       out_addr_q, out_addr_d;
`endif

    logic             csr_wr, wr_ctrl, wr_status, wr_len, entry_hit, wr_entry;
    logic [IDX_W-1:0] ent_idx, cur_idx;
    logic [3:0]       len_eff;
    logic             last_entry, run_eff, done_set, expire;
    logic             unused_wdata;

    assign csr_wr    = csr_chipselect & ~csr_write_n;
    assign wr_ctrl   = csr_wr & (csr_address == CSR_CTRL);
    assign wr_status = csr_wr & (csr_address == CSR_STATUS);
    assign wr_len    = csr_wr & (csr_address == CSR_LEN);
    assign entry_hit = csr_address[3] & ({1'b0, csr_address[2:0]} < DEPTH_L);
    assign wr_entry  = csr_wr & entry_hit;
    assign ent_idx   = csr_address[IDX_W-1:0];
    assign cur_idx   = idx_q[IDX_W-1:0];
    assign unused_wdata = ^csr_writedata;

    assign len_eff    = (len_q > DEPTH_L) ? DEPTH_L : len_q;
    // ">=" rather than "==" so a LEN shrunk below the current index still ends the pass.
    assign last_entry = (({1'b0, idx_q} + 4'd1) >= len_eff);
    // A RUN clear written this cycle takes effect immediately in LOAD/HOLD/NEXT.
    assign run_eff    = run_q & ~(wr_ctrl & ~csr_writedata[CTRL_RUN]);

    // Pattern table and LEN
    always_comb begin
        pat_d = pat_q;
        dur_d = dur_q;
        len_d = wr_len ? csr_writedata[3:0] : len_q;
`ifdef LED_SEQ_SETCLR_EN
        mode_d = mode_q;
`endif
        if (wr_entry) begin
            pat_d[ent_idx] = csr_writedata[LED_W-1:0];
            dur_d[ent_idx] = csr_writedata[ENTRY_DUR_LSB +: DUR_W];
`ifdef LED_SEQ_SETCLR_EN
            mode_d[ent_idx] = csr_writedata[ENTRY_MODE_LSB +: 2];
`endif
        end
    end

    // Control register and sequencing FSM
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_d     = run_q;
        loop_d    = loop_q;
        irq_en_d  = irq_en_q;
        out_pat_d = out_pat_q;
        out_dur_d = out_dur_q;
`ifdef LED_SEQ_SETCLR_EN
        out_addr_d = out_addr_q;
`endif
        done_set  = 1'b0;

        if (wr_ctrl) begin
            loop_d   = csr_writedata[CTRL_LOOP];
            irq_en_d = csr_writedata[CTRL_IRQ_EN];
            if (state_q == StIdle) begin
                run_d = 1'b0;
                if (csr_writedata[CTRL_RUN]) begin
                    if (len_eff != 4'd0) begin
                        run_d   = 1'b1;
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end else begin
                // While busy, RUN can only be cleared; writing 1 never restarts.
                run_d = run_q & csr_writedata[CTRL_RUN];
            end
        end

        case (state_q)
            StIdle: ;
            StLoad: begin
                if (!run_eff) begin
                    state_d = StIdle;
                end else begin
                    out_pat_d = pat_q[cur_idx];
                    out_dur_d = dur_q[cur_idx];
`ifdef LED_SEQ_SETCLR_EN
                    out_addr_d = mode_to_addr(mode_q[cur_idx]);
`endif
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Never abandon an asserted write: only leave once accepted.
                if (!m_waitrequest) state_d = run_eff ? StHold : StIdle;
            end
            StHold: begin
                if (!run_eff)    state_d = StIdle;
                else if (expire) state_d = StNext;
            end
            StNext: begin
                if (!run_eff) begin
                    state_d = StIdle;
                end else if (last_entry) begin
                    if (loop_q) begin
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        done_set = 1'b1;
                        run_d    = 1'b0;
                        state_d  = StIdle;
                    end
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Hardware set wins over a simultaneous write-1-clear.
    always_comb begin
        done_d = done_q;
        if (wr_status && csr_writedata[STAT_DONE]) done_d = 1'b0;
        if (done_set)                              done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            run_q     <= 1'b0;
            loop_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            out_pat_q <= '0;
            out_dur_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pat_q[i] <= '0;
                dur_q[i] <= '0;
`ifdef LED_SEQ_SETCLR_EN
                mode_q[i] <= '0;
`endif
            end
`ifdef LED_SEQ_SETCLR_EN
            out_addr_q <= PIO_DATA;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_q     <= run_d;
            loop_q    <= loop_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            len_q     <= len_d;
            out_pat_q <= out_pat_d;
            out_dur_q <= out_dur_d;
            pat_q     <= pat_d;
            dur_q     <= dur_d;
`ifdef LED_SEQ_SETCLR_EN
            mode_q     <= mode_d;
            out_addr_q <= out_addr_d;
`endif
        end
    end

    led_seq_tick #(
        .TICK_DIV (TICK_DIV),
        .DUR_W    (DUR_W)
    ) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (state_q != StHold),
        .duration (out_dur_q),
        .expire   (expire)
    );

    // CSR readback
    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            CSR_CTRL: begin
                csr_readdata[CTRL_RUN]    = run_q;
                csr_readdata[CTRL_LOOP]   = loop_q;
                csr_readdata[CTRL_IRQ_EN] = irq_en_q;
            end
            CSR_STATUS: begin
                csr_readdata[STAT_BUSY]          = (state_q != StIdle);
                csr_readdata[STAT_IDX_LSB +: 3]  = idx_q;
                csr_readdata[STAT_DONE]          = done_q;
            end
            CSR_LEN: csr_readdata[3:0] = len_q;
            default: begin
                if (entry_hit) begin
                    csr_readdata[LED_W-1:0]              = pat_q[ent_idx];
                    csr_readdata[ENTRY_DUR_LSB +: DUR_W] = dur_q[ent_idx];
`ifdef LED_SEQ_SETCLR_EN
                    csr_readdata[ENTRY_MODE_LSB +: 2]    = mode_q[ent_idx];
`endif
                end
            end
        endcase
    end

    assign m_chipselect = (state_q == StWrite);
    assign m_write_n    = (state_q != StWrite);
    assign m_writedata  = {{(32 - LED_W){1'b0}}, out_pat_q};
`ifdef LED_SEQ_SETCLR_EN
    assign m_address    = out_addr_q;
`else
    assign m_address    = PIO_DATA;
`endif
    assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed self-checking bench for led_pio_sequencer (TICK_DIV=4).
module tb_led_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  csr_address = 4'd1;
    logic        csr_chipselect = 1'b0;
    logic        csr_write_n = 1'b1;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        irq;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [31:0] log_data [$];
    logic [2:0]  log_addr [$];
    int          log_cyc  [$];

    led_pio_sequencer #(
        .LED_W    (7),
        .DEPTH    (8),
        .TICK_DIV (4),
        .DUR_W    (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write_n    (csr_write_n),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .m_address      (m_address),
        .m_chipselect   (m_chipselect),
        .m_write_n      (m_write_n),
        .m_writedata    (m_writedata),
        .m_waitrequest  (m_waitrequest),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // Accepted PIO writes, sampled mid-cycle ahead of the accepting edge.
    always @(negedge clk) begin
        cyc++;
        if (m_chipselect && !m_write_n && !m_waitrequest) begin
            log_data.push_back(m_writedata);
            log_addr.push_back(m_address);
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [3:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        csr_address    = addr;
        csr_writedata  = data;
        csr_chipselect = 1'b1;
        csr_write_n    = 1'b0;
        @(posedge clk); #1;
        csr_chipselect = 1'b0;
        csr_write_n    = 1'b1;
        csr_address    = 4'd1;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] addr, input logic [31:0] mask,
                            input logic [31:0] exp);
        csr_address = addr;
        #1;
        check(tag, csr_readdata & mask, exp);
        csr_address = 4'd1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #2;
            csr_address = 4'd1;
            #1;
            if (!csr_readdata[0]) break;
        end
        check(tag, {31'd0, csr_readdata[0]}, 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int n, input int max);
        for (int i = 0; i < max; i++) begin
            if (log_data.size() >= n) break;
            @(posedge clk); #2;
        end
        check(tag, log_data.size(), n);
    endtask

    int base;

    initial begin
        // Reset state
        #12;
        check("rst_cs", {31'd0, m_chipselect}, 32'd0);
        check("rst_wn", {31'd0, m_write_n}, 32'd1);
        check("rst_addr", {29'd0, m_address}, 32'd0);
        check("rst_wdata", m_writedata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        read_chk("rst_ctrl", 4'd0, 32'hFFFF_FFFF, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: two-entry one-shot
        csr_wr(4'd2, 32'd2);
        csr_wr(4'd8, 32'h0002_0055);
        csr_wr(4'd9, 32'h0001_002A);
        read_chk("entry0_rb", 4'd8, 32'hFFFF_FFFF, 32'h0002_0055);
        csr_wr(4'd0, 32'd1);
        @(negedge clk);
        check("t1_load_cs", {31'd0, m_chipselect}, 32'd0);
        @(negedge clk);
        check("t1_write_cs", {31'd0, m_chipselect}, 32'd1);
        check("t1_write_wn", {31'd0, m_write_n}, 32'd0);
        check("t1_write_data", m_writedata, 32'h55);
        check("t1_write_addr", {29'd0, m_address}, 32'd0);
        wait_idle("t1_idle", 200);
        check("t1_nwrites", log_data.size(), 2);
        check("t1_data0", log_data[0], 32'h55);
        check("t1_data1", log_data[1], 32'h2A);
        check("t1_gap", log_cyc[1] - log_cyc[0], 11);
        read_chk("t1_status", 4'd1, 32'h171, 32'h110);
        read_chk("t1_ctrl", 4'd0, 32'h7, 32'h0);
        check("t1_irq", {31'd0, irq}, 32'd0);
        csr_wr(4'd1, 32'h100);
        read_chk("t1_done_clr", 4'd1, 32'h100, 32'h0);

        // 2: loop, then stop during HOLD
        base = log_data.size();
        csr_wr(4'd0, 32'd3);
        wait_writes("t2_three", base + 3, 200);
        csr_wr(4'd0, 32'd2);
        read_chk("t2_stop_busy", 4'd1, 32'h1, 32'h0);
        repeat (30) @(negedge clk);
        check("t2_nwrites", log_data.size(), base + 3);
        check("t2_d0", log_data[base], 32'h55);
        check("t2_d1", log_data[base+1], 32'h2A);
        check("t2_d2", log_data[base+2], 32'h55);
        read_chk("t2_status", 4'd1, 32'h101, 32'h0);
        check("t2_leds_kept", m_writedata, 32'h55);

        // 3: stall, with RUN cleared mid-stall
        @(posedge clk); #1;
        m_waitrequest = 1'b1;
        base = log_data.size();
        csr_wr(4'd0, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                csr_address    = 4'd0;
                csr_writedata  = 32'd0;
                csr_chipselect = 1'b1;
                csr_write_n    = 1'b0;
            end else if (i == 3) begin
                csr_chipselect = 1'b0;
                csr_write_n    = 1'b1;
                csr_address    = 4'd1;
            end
            if (i == 5) m_waitrequest = 1'b0;
            @(negedge clk);
            check("t3_stall_cs", {31'd0, m_chipselect}, 32'd1);
            check("t3_stall_data", m_writedata, 32'h55);
            check("t3_stall_addr", {29'd0, m_address}, 32'd0);
        end
        @(negedge clk);
        check("t3_after_cs", {31'd0, m_chipselect}, 32'd0);
        check("t3_one_write", log_data.size(), base + 1);
        read_chk("t3_status", 4'd1, 32'h101, 32'h0);
        repeat (20) @(negedge clk);
        check("t3_no_more", log_data.size(), base + 1);

        // LEN clamp and zero-duration entries
        for (int i = 0; i < 8; i++) csr_wr(4'(8 + i), 32'(i + 1));
        csr_wr(4'd2, 32'd12);
        base = log_data.size();
        csr_wr(4'd0, 32'd1);
        wait_idle("clamp_idle", 300);
        check("clamp_nwrites", log_data.size(), base + 8);
        check("clamp_first", log_data[base], 32'h1);
        check("clamp_last", log_data[base+7], 32'h8);
        check("clamp_gap", log_cyc[base+1] - log_cyc[base], 4);
        read_chk("clamp_status", 4'd1, 32'h171, 32'h170);
        csr_wr(4'd1, 32'h100);

        // Unmapped address
        csr_wr(4'd3, 32'hFFFF_FFFF);
        read_chk("unmapped_rb", 4'd3, 32'hFFFF_FFFF, 32'h0);

        // 4: LEN=0 start, IRQ
        csr_wr(4'd2, 32'd0);
        csr_wr(4'd0, 32'd4);
        base = log_data.size();
        csr_wr(4'd0, 32'd5);
        read_chk("t4_status", 4'd1, 32'h101, 32'h100);
        read_chk("t4_ctrl", 4'd0, 32'h7, 32'h4);
        check("t4_irq", {31'd0, irq}, 32'd1);
        repeat (10) @(negedge clk);
        check("t4_no_writes", log_data.size(), base);
        csr_wr(4'd1, 32'h100);
        @(negedge clk);
        check("t4_irq_clr", {31'd0, irq}, 32'd0);

        // 5: asynchronous reset mid-HOLD
        csr_wr(4'd2, 32'd2);
        csr_wr(4'd8, 32'h0002_0055);
        base = log_data.size();
        csr_wr(4'd0, 32'd1);
        wait_writes("t5_first", base + 1, 50);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_cs", {31'd0, m_chipselect}, 32'd0);
        check("t5_rst_wn", {31'd0, m_write_n}, 32'd1);
        check("t5_rst_wdata", m_writedata, 32'd0);
        check("t5_rst_addr", {29'd0, m_address}, 32'd0);
        check("t5_rst_irq", {31'd0, irq}, 32'd0);
        read_chk("t5_rst_status", 4'd1, 32'hFFFF_FFFF, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_no_writes", log_data.size(), base + 1);
        read_chk("t5_ctrl", 4'd0, 32'hFFFF_FFFF, 32'h0);
        read_chk("t5_entry0", 4'd8, 32'hFFFF_FFFF, 32'h0);

`ifdef LED_SEQ_SETCLR_EN
        // 6: set/clear write modes
        csr_wr(4'd2, 32'd2);
        csr_wr(4'd8, 32'h0000_0101);
        csr_wr(4'd9, 32'h0000_0201);
        base = log_data.size();
        csr_wr(4'd0, 32'd1);
        wait_idle("t6_idle", 100);
        check("t6_nwrites", log_data.size(), base + 2);
        check("t6_addr0", {29'd0, log_addr[base]}, 32'd4);
        check("t6_addr1", {29'd0, log_addr[base+1]}, 32'd5);
        check("t6_data0", log_data[base], 32'h1);
        check("t6_data1", log_data[base+1], 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
